id_stage_hazard: RTL and testbench

Parametrised successor to the pipeline decode stage. Contains the register file with write-through bypass, sign extension, and the branch-target adder. Adds early branch resolution (BEQ/BNE) with MEM-stage forwarding, load-use and branch-hazard stall detection, an ID/EX pipeline register with bubble insertion, and a saturating stall counter. Sits between the IF/ID register and the EX stage of the MIPS pipeline.

---
 rtl/id_stage_hazard_pkg.sv | 30 +++
 rtl/id_stage_hazard_regfile_bypass.sv | 46 ++++
 rtl/id_stage_hazard.sv | 188 ++++++++++++++++++
 tb/tb_id_stage_hazard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_hazard_pkg.sv
// rtl/id_stage_hazard_pkg.sv - opcodes, instruction field positions and hazard flags for the decode stage
package id_stage_hazard_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int OPC_LSB   = 26;
  localparam int OPC_W     = 6;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W   = 6;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 16;

  // One flag per stall cause so the reason for a bubble is visible in a waveform.
  typedef struct packed {
    logic load_use;
    logic branch_ex;
    logic branch_mem_load;
  } hazard_t;

  function automatic logic is_branch(input logic [OPC_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_stage_hazard_regfile_bypass.sv
// rtl/id_stage_hazard_regfile_bypass.sv - 2R/1W register file with hard-wired zero and write-through bypass
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next register contents: the write port updates one entry, entry 0 never changes.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // A write in the same cycle as a read is forwarded so WB and ID need no extra stall.
  assign rdata_a = (raddr_a == '0)                 ? '0    :
                   (we && (waddr == raddr_a))      ? wdata :
                                                     regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0)                 ? '0    :
                   (we && (waddr == raddr_b))      ? wdata :
                                                     regs_q[raddr_b];

endmodule

// File: rtl/id_stage_hazard.sv
// rtl/id_stage_hazard.sv - decode stage with early branch resolution, hazard stalls and ID/EX register
module id_stage_hazard
  import id_stage_hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 16,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_we,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_we,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              stall,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              idex_valid,
  output logic [5:0]        idex_opcode,
  output logic [5:0]        idex_funct,
  output logic [REG_AW-1:0] idex_rs,
  output logic [REG_AW-1:0] idex_rt,
  output logic [REG_AW-1:0] idex_rd,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [OPC_W-1:0]   opcode;
  logic [FUNCT_W-1:0] funct;
  logic [REG_AW-1:0]  rs, rt, rd;
  logic [IMM_W-1:0]   imm16;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  rs_data, rt_data;
  logic [DATA_W-1:0]  cmp_a, cmp_b;
  logic               branch;
  hazard_t            hz;

  assign opcode  = instr[OPC_LSB +: OPC_W];
  assign funct   = instr[FUNCT_LSB +: FUNCT_W];
  assign rs      = instr[RS_LSB +: REG_AW];
  assign rt      = instr[RT_LSB +: REG_AW];
  assign rd      = instr[RD_LSB +: REG_AW];
  assign imm16   = instr[IMM_LSB +: IMM_W];
  assign imm_ext = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
  assign branch  = is_branch(opcode);

  regfile_bypass #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .rdata_a (rs_data),
    .raddr_b (rt),
    .rdata_b (rt_data)
  );

  function automatic logic src_hit(input logic [REG_AW-1:0] r,
                                   input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return (r != '0) && ((r == a) || (r == b));
  endfunction

  // Hazard causes; a branch cannot use an ALU result still in EX nor a load result still in MEM.
  always_comb begin
    hz                 = '0;
    hz.load_use        = ex_mem_read && src_hit(ex_rd, rs, rt);
    hz.branch_ex       = branch && ex_we && src_hit(ex_rd, rs, rt);
    hz.branch_mem_load = branch && mem_we && mem_mem_read && src_hit(mem_rd, rs, rt);
  end

  assign stall = valid_in && (|hz);

  // Comparator operands: a non-load result in MEM is fresher than the file (and WB) value.
  always_comb begin
    cmp_a = rs_data;
    cmp_b = rt_data;
    if (mem_we && !mem_mem_read && (mem_rd != '0) && (mem_rd == rs)) begin
      cmp_a = mem_data;
    end
    if (mem_we && !mem_mem_read && (mem_rd != '0) && (mem_rd == rt)) begin
      cmp_b = mem_data;
    end
  end

  assign branch_taken  = valid_in && !stall &&
                         (((opcode == OP_BEQ) && (cmp_a == cmp_b)) ||
                          ((opcode == OP_BNE) && (cmp_a != cmp_b)));
  assign branch_target = pc_plus4 + (imm_ext << 2);

  logic              idex_valid_q, idex_valid_d;
  logic [5:0]        idex_opcode_q, idex_opcode_d;
  logic [5:0]        idex_funct_q, idex_funct_d;
  logic [REG_AW-1:0] idex_rs_q, idex_rs_d;
  logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  logic [DATA_W-1:0] idex_rs_data_q, idex_rs_data_d;
  logic [DATA_W-1:0] idex_rt_data_q, idex_rt_data_d;
  logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // ID/EX next state: capture a real, unstalled instruction, otherwise an all-zero bubble.
  always_comb begin
    idex_valid_d   = 1'b0;
    idex_opcode_d  = '0;
    idex_funct_d   = '0;
    idex_rs_d      = '0;
    idex_rt_d      = '0;
    idex_rd_d      = '0;
    idex_rs_data_d = '0;
    idex_rt_data_d = '0;
    idex_imm_d     = '0;
    if (valid_in && !stall) begin
      idex_valid_d   = 1'b1;
      idex_opcode_d  = opcode;
      idex_funct_d   = funct;
      idex_rs_d      = rs;
      idex_rt_d      = rt;
      idex_rd_d      = rd;
      idex_rs_data_d = rs_data;
      idex_rt_data_d = rt_data;
      idex_imm_d     = imm_ext;
    end
  end

  // Stall counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline register and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid_q   <= 1'b0;
      idex_opcode_q  <= '0;
      idex_funct_q   <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_rd_q      <= '0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_imm_q     <= '0;
      stall_cnt_q    <= '0;
    end else begin
      idex_valid_q   <= idex_valid_d;
      idex_opcode_q  <= idex_opcode_d;
      idex_funct_q   <= idex_funct_d;
      idex_rs_q      <= idex_rs_d;
      idex_rt_q      <= idex_rt_d;
      idex_rd_q      <= idex_rd_d;
      idex_rs_data_q <= idex_rs_data_d;
      idex_rt_data_q <= idex_rt_data_d;
      idex_imm_q     <= idex_imm_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign idex_valid   = idex_valid_q;
  assign idex_opcode  = idex_opcode_q;
  assign idex_funct   = idex_funct_q;
  assign idex_rs      = idex_rs_q;
  assign idex_rt      = idex_rt_q;
  assign idex_rd      = idex_rd_q;
  assign idex_rs_data = idex_rs_data_q;
  assign idex_rt_data = idex_rt_data_q;
  assign idex_imm     = idex_imm_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// tb/tb_id_stage_hazard.sv - scoreboard bench for id_stage_hazard
module tb_id_stage_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_we, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_we, mem_mem_read;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic        idex_valid;
  logic [5:0]  idex_opcode, idex_funct;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [31:0] idex_rs_data, idex_rt_data, idex_imm;
  logic [1:0]  stall_cnt;

  always #5 clk = ~clk;

  id_stage_hazard #(.DATA_W(32), .NREGS(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr(instr), .pc_plus4(pc_plus4),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_we(ex_we), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_we(mem_we), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .mem_data(mem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .idex_valid(idex_valid), .idex_opcode(idex_opcode), .idex_funct(idex_funct),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
    .stall_cnt(stall_cnt)
  );

  logic [123:0] idex_act;
  assign idex_act = {idex_valid, idex_opcode, idex_funct, idex_rs, idex_rt, idex_rd,
                     idex_rs_data, idex_rt_data, idex_imm};

  typedef struct {
    string        name;
    logic         stall;
    logic         bt;
    logic         chk_tgt;
    logic [31:0]  tgt;
    logic [123:0] idex;
    logic [1:0]   cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic busy  = 1'b0;

  localparam logic [123:0] BUBBLE = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [123:0] cap(input logic [31:0] ins, input logic [31:0] rsd,
                                       input logic [31:0] rtd);
    return {1'b1, ins[31:26], ins[5:0], ins[25:21], ins[20:16], ins[15:11], rsd, rtd,
            {{16{ins[15]}}, ins[15:0]}};
  endfunction

  task automatic push(input string name, input logic st, input logic bt, input logic ct,
                      input logic [31:0] tgt, input logic [123:0] idex, input logic [1:0] cnt);
    exp_t e;
    e.name = name; e.stall = st; e.bt = bt; e.chk_tgt = ct; e.tgt = tgt; e.idex = idex; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_in = 0; instr = '0; pc_plus4 = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;
    ex_we = 0; ex_mem_read = 0; ex_rd = '0;
    mem_we = 0; mem_mem_read = 0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q.size() != 0 || busy); i++) @(posedge clk);
    #2;
    if (q.size() != 0 || busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        busy = 1'b1;
        e = q.pop_front();
        chk({e.name, ".stall"}, 128'(stall), 128'(e.stall));
        chk({e.name, ".branch_taken"}, 128'(branch_taken), 128'(e.bt));
        if (e.chk_tgt) chk({e.name, ".branch_target"}, 128'(branch_target), 128'(e.tgt));
        @(posedge clk);
        #1;
        chk({e.name, ".idex"}, 128'(idex_act), 128'(e.idex));
        chk({e.name, ".stall_cnt"}, 128'(stall_cnt), 128'(e.cnt));
        busy = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] i_lu, i_beq, i_bne, i_br2, i_bne2, i_last;
    rst = 1'b1;
    clear_in();
    #12;
    chk("reset.idex", 128'(idex_act), 128'(BUBBLE));
    chk("reset.stall_cnt", 128'(stall_cnt), 128'(0));
    chk("reset.stall", 128'(stall), 128'(0));
    chk("reset.branch_taken", 128'(branch_taken), 128'(0));
    step();
    rst = 1'b0;

    // C1: WB writes r5 while ID reads rs=5
    valid_in = 1; instr = rtype(5'd5, 5'd0, 5'd2, 6'h20);
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234;
    push("wb_bypass", 0, 0, 0, '0, cap(instr, 32'h1234, 32'h0), 2'd0); step();
    // C2: r0 write ignored even through bypass
    instr = rtype(5'd0, 5'd5, 5'd3, 6'h20); wb_addr = 5'd0; wb_data = 32'hFFFF;
    push("r0_write", 0, 0, 0, '0, cap(instr, 32'h0, 32'h1234), 2'd0); step();
    // C3: r0 still zero afterwards; write r3=7
    instr = rtype(5'd0, 5'd0, 5'd4, 6'h25); wb_addr = 5'd3; wb_data = 32'd7;
    push("r0_read", 0, 0, 0, '0, cap(instr, 32'h0, 32'h0), 2'd0); step();
    // C4: load-use on rt=8; write r4=7
    i_lu = rtype(5'd1, 5'd8, 5'd6, 6'h20);
    instr = i_lu; wb_addr = 5'd4; wb_data = 32'd7;
    ex_we = 1; ex_mem_read = 1; ex_rd = 5'd8;
    push("load_use", 1, 0, 0, '0, BUBBLE, 2'd1); step();
    // C5: load now in MEM, its value arrives via WB bypass
    ex_we = 0; ex_mem_read = 0; ex_rd = '0;
    mem_we = 1; mem_mem_read = 1; mem_rd = 5'd8; mem_data = 32'hDEAD;
    wb_addr = 5'd8; wb_data = 32'hCAFE;
    push("load_use_release", 0, 0, 0, '0, cap(i_lu, 32'h0, 32'hCAFE), 2'd1); step();
    // C6: BEQ r3,r4 taken; write r9=3
    mem_we = 0; mem_mem_read = 0; mem_rd = '0; mem_data = '0;
    i_beq = itype(6'h04, 5'd3, 5'd4, 16'h0004); instr = i_beq; pc_plus4 = 32'h100;
    wb_addr = 5'd9; wb_data = 32'd3;
    push("beq_taken", 0, 1, 1, 32'h110, cap(i_beq, 32'd7, 32'd7), 2'd1); step();
    // C7: BNE rs=9 forwarded from MEM (3) vs r3=3 -> not taken
    i_bne = itype(6'h05, 5'd9, 5'd3, 16'hFFFC); instr = i_bne; pc_plus4 = 32'h200;
    mem_we = 1; mem_rd = 5'd9; mem_data = 32'd3;
    wb_addr = 5'd3; wb_data = 32'd3;
    push("bne_fwd_equal", 0, 0, 1, 32'h1F0, cap(i_bne, 32'd3, 32'd3), 2'd1); step();
    // C8: MEM forward 5 beats WB 0x77 on r9 for the comparator; ID/EX takes WB value
    mem_data = 32'd5; wb_addr = 5'd9; wb_data = 32'h77;
    push("bne_fwd_priority", 0, 1, 1, 32'h1F0, cap(i_bne, 32'h77, 32'd3), 2'd1); step();
    // C9: BEQ on a load in EX
    mem_we = 0; mem_rd = '0; mem_data = '0; wb_we = 0; wb_addr = '0; wb_data = '0;
    i_br2 = itype(6'h04, 5'd10, 5'd9, 16'h0003); instr = i_br2; pc_plus4 = 32'h40;
    ex_we = 1; ex_mem_read = 1; ex_rd = 5'd10;
    push("br_load_ex", 1, 0, 1, 32'h4C, BUBBLE, 2'd2); step();
    // C10: same load now in MEM
    ex_we = 0; ex_mem_read = 0; ex_rd = '0;
    mem_we = 1; mem_mem_read = 1; mem_rd = 5'd10;
    push("br_load_mem", 1, 0, 1, 32'h4C, BUBBLE, 2'd3); step();
    // C11: load in WB, resolves taken (r10=0x77 == r9=0x77)
    mem_we = 0; mem_mem_read = 0; mem_rd = '0;
    wb_we = 1; wb_addr = 5'd10; wb_data = 32'h77;
    push("br_load_resolve", 0, 1, 1, 32'h4C, cap(i_br2, 32'h77, 32'h77), 2'd3); step();
    // C12: BNE with ALU producer of rt in EX; counter saturated
    wb_we = 0; wb_addr = '0; wb_data = '0;
    i_bne2 = itype(6'h05, 5'd9, 5'd3, 16'h0010); instr = i_bne2; pc_plus4 = 32'h80;
    ex_we = 1; ex_rd = 5'd3;
    push("br_ex_alu", 1, 0, 1, 32'hC0, BUBBLE, 2'd3); step();
    // C13: producer in MEM forwards 0x77 on rt -> equal -> BNE not taken
    ex_we = 0; ex_rd = '0;
    mem_we = 1; mem_rd = 5'd3; mem_data = 32'h77;
    push("br_mem_fwd_rt", 0, 0, 1, 32'hC0, cap(i_bne2, 32'h77, 32'd3), 2'd3); step();
    // C14: invalid slot never stalls
    mem_we = 0; mem_rd = '0; mem_data = '0;
    valid_in = 0; instr = i_lu; ex_we = 1; ex_mem_read = 1; ex_rd = 5'd8;
    push("invalid_gated", 0, 0, 0, '0, BUBBLE, 2'd3); step();
    // C15: plain capture
    ex_we = 0; ex_mem_read = 0; ex_rd = '0;
    valid_in = 1; i_last = rtype(5'd9, 5'd3, 5'd7, 6'h22); instr = i_last;
    push("capture", 0, 0, 0, '0, cap(i_last, 32'h77, 32'd3), 2'd3); step();
    drain();

    // Asynchronous reset pulse between edges
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.idex", 128'(idex_act), 128'(BUBBLE));
    chk("async_rst.stall_cnt", 128'(stall_cnt), 128'(0));
    #1 rst = 1'b0;
    step();

    // Five consecutive load-use stalls on a 2-bit counter
    valid_in = 1; instr = i_lu; ex_we = 1; ex_mem_read = 1; ex_rd = 5'd8;
    push("sat1", 1, 0, 0, '0, BUBBLE, 2'd1); step();
    push("sat2", 1, 0, 0, '0, BUBBLE, 2'd2); step();
    push("sat3", 1, 0, 0, '0, BUBBLE, 2'd3); step();
    push("sat4", 1, 0, 0, '0, BUBBLE, 2'd3); step();
    push("sat5", 1, 0, 0, '0, BUBBLE, 2'd3); step();
    drain();

    // Reset in the middle of a stall
    @(negedge clk);
    #1;
    chk("mid_stall.stall", 128'(stall), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_stall_rst.idex", 128'(idex_act), 128'(BUBBLE));
    chk("mid_stall_rst.stall_cnt", 128'(stall_cnt), 128'(0));
    valid_in = 0;
    #1;
    chk("mid_stall_rst.stall", 128'(stall), 128'(0));
    chk("mid_stall_rst.branch_taken", 128'(branch_taken), 128'(0));
    step();
    clear_in();
    rst = 1'b0;

    // Register file cleared by reset
    valid_in = 1; i_last = rtype(5'd9, 5'd8, 5'd1, 6'h20); instr = i_last;
    push("regs_cleared", 0, 0, 0, '0, cap(i_last, 32'h0, 32'h0), 2'd0); step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
